// File: rtl/tbus_rx.sv
// tbus_rx: receives one WIDTH-bit word, LSB first, from one of two drivers
// (M or N) that share a tri-state line. It also generates their output enables.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start, src       transfer request and source select (0 = M, 1 = N)
//   s                shared bus line
//   oe_m, oe_n       registered driver enables
//   busy             high in any state other than IDLE
//   data, valid      received word and its valid flag
//   ready            consumer handshake; data is accepted on valid && ready
module tbus_rx #(
    parameter int WIDTH = 8,
    parameter int TURN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             src,
    input  logic             s,
    output logic             oe_m,
    output logic             oe_n,
    output logic             busy,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST  = BW'(WIDTH - 1);
    localparam logic [2:0]    TLOAD = 3'(TURN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TURN,
        S_RECV,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic             r_src;
    logic [2:0]       r_tcnt;
    logic [BW-1:0]    r_bcnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_oe_m;
    logic             r_oe_n;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] w_shift;

    // The shift register with the current bus sample placed at the bit count.
    // On the last sample this is the complete word.
    always_comb begin
        w_shift         = r_shift;
        w_shift[r_bcnt] = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_src   <= 1'b0;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_oe_m  <= 1'b0;
            r_oe_n  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src   <= src;
                        r_tcnt  <= TLOAD;
                        r_bcnt  <= '0;
                        r_shift <= '0;
                        r_oe_m  <= ~src;
                        r_oe_n  <= src;
                        r_busy  <= 1'b1;
                        r_state <= S_TURN;
                    end
                end
                S_TURN: begin
                    // The bus is still turning around, so s is not sampled.
                    r_oe_m <= ~r_src;
                    r_oe_n <= r_src;
                    if (r_tcnt == 3'd0) begin
                        r_state <= S_RECV;
                    end else begin
                        r_tcnt <= r_tcnt - 3'd1;
                    end
                end
                S_RECV: begin
                    r_shift <= w_shift;
                    if (r_bcnt == LAST) begin
                        // Release the bus on the same edge that publishes the word.
                        r_data  <= w_shift;
                        r_oe_m  <= 1'b0;
                        r_oe_n  <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end else begin
                        r_oe_m <= ~r_src;
                        r_oe_n <= r_src;
                        r_bcnt <= r_bcnt + BW'(1);
                    end
                end
                S_HOLD: begin
                    if (ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oe_m  = r_oe_m;
    assign oe_n  = r_oe_n;
    assign busy  = r_busy;
    assign data  = r_data;
    assign valid = r_valid;

endmodule
